// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared types and constants for the instruction/data memory port arbiter.
//   owner_e      : which port owns the read currently returning from the RAM
//   MEM_SEL_ALL  : byte-enable pattern for a full-word fetch read
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam logic [3:0] MEM_SEL_ALL = 4'hF;

endpackage : mem_port_arbiter_pkg

// File: rtl/arb_starve_ctr.sv
// ---------------------------------------------------------------------------
// arb_starve_ctr
// Counts consecutive cycles in which the data port beat a pending fetch.
// Saturates at MAX and flags at_max_o, which forces the next contested grant
// to the fetch port.
// Ports:
//   clock     : rising-edge clock
//   reset     : synchronous, active-high
//   inc_i     : data won against a pending fetch this cycle
//   clr_i     : fetch won, or no fetch is pending
//   at_max_o  : counter equals MAX
// ---------------------------------------------------------------------------
module arb_starve_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);

  localparam int unsigned W = $clog2(MAX + 1);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign at_max_o = (cnt_q == MAX_V);

endmodule : arb_starve_ctr

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported, 1-cycle-latency synchronous RAM between the CPU
// fetch port and the data load/store port. One access per cycle, data port
// has priority, fetch is forced through after STARVE_MAX consecutive losses.
// Ports:
//   clock, reset              : clock and synchronous active-high reset
//   if_req_i/if_addr_i        : fetch read request
//   if_flush_i                : masks this cycle's fetch and kills a returning fetch read
//   if_gnt_o/if_rvalid_o/if_rdata_o : fetch grant and read return
//   d_req_i/d_we_i/d_sel_i/d_addr_i/d_wdata_i : data request
//   d_gnt_o/d_rvalid_o/d_rdata_o    : data grant and read return
//   mem_*_o / mem_rdata_i     : RAM command and read data
//   conflict_cnt_o            : saturating count of cycles with both ports requesting
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [3:0]        d_sel_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_ce_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_sel_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [31:0]       conflict_cnt_o
);

  logic   fr, dr, both;
  logic   if_win, d_win;
  logic   at_max;
  owner_e owner_q, owner_d;
  logic [31:0] conflict_q, conflict_d;

  // Effective requests: reset and flush suppress everything combinationally.
  assign fr   = if_req_i & ~if_flush_i & ~reset;
  assign dr   = d_req_i & ~reset;
  assign both = fr & dr;

  // Data has priority unless fetch has lost STARVE_MAX contested cycles in a row.
  assign if_win = fr & (~dr | at_max);
  assign d_win  = dr & ~if_win;

  assign if_gnt_o = if_win;
  assign d_gnt_o  = d_win;

  arb_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clock    (clock),
    .reset    (reset),
    .inc_i    (both & d_win),
    .clr_i    (if_win | ~fr),
    .at_max_o (at_max)
  );

  always_comb begin
    mem_ce_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_sel_o   = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    owner_d     = OWN_NONE;
    if (if_win) begin
      mem_ce_o   = 1'b1;
      mem_sel_o  = MEM_SEL_ALL;
      mem_addr_o = if_addr_i;
      owner_d    = OWN_IF;
    end else if (d_win) begin
      mem_ce_o    = 1'b1;
      mem_we_o    = d_we_i;
      mem_sel_o   = d_sel_i;
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
      // Writes return nothing, so they leave no owner behind.
      owner_d     = d_we_i ? OWN_NONE : OWN_D;
    end
  end

  always_comb begin
    conflict_d = conflict_q;
    if (both && (conflict_q != 32'hFFFF_FFFF)) conflict_d = conflict_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q    <= OWN_NONE;
      conflict_q <= '0;
    end else begin
      owner_q    <= owner_d;
      conflict_q <= conflict_d;
    end
  end

  // Gating with reset hides a read that was granted the cycle before reset rose.
  // A flush discards a returning fetch; the RAM access itself already happened.
  assign if_rvalid_o    = (owner_q == OWN_IF) & ~if_flush_i & ~reset;
  assign d_rvalid_o     = (owner_q == OWN_D) & ~reset;
  assign if_rdata_o     = mem_rdata_i;
  assign d_rdata_o      = mem_rdata_i;
  assign conflict_cnt_o = conflict_q;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed scenarios followed by random traffic, all checked against a
// cycle-level reference model kept in integer variables.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req_i, if_flush_i, if_gnt_o, if_rvalid_o;
  logic [31:0] if_addr_i, if_rdata_o;
  logic        d_req_i, d_we_i, d_gnt_o, d_rvalid_o;
  logic [3:0]  d_sel_i;
  logic [31:0] d_addr_i, d_wdata_i, d_rdata_o;
  logic        mem_ce_o, mem_we_o;
  logic [3:0]  mem_sel_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [31:0] conflict_cnt_o;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clock(clock), .reset(reset),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_sel_i(d_sel_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
    .d_rdata_o(d_rdata_o), .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o),
    .mem_sel_o(mem_sel_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .conflict_cnt_o(conflict_cnt_o)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state: who is owed read data next cycle (0 none, 1 fetch,
  // 2 data), consecutive contested data wins, and contested-cycle count.
  int     m_owed     = 0;
  int     m_starve   = 0;
  longint m_conflict = 0;
  // Decisions for the current cycle, applied to the model at the clock edge.
  bit c_rst, c_fr, c_dr, c_ifw, c_dw, c_we;

  task automatic drive(input logic rst, input logic ireq, input logic fl,
                       input logic [31:0] iaddr, input logic dreq, input logic we,
                       input logic [3:0] sel, input logic [31:0] daddr,
                       input logic [31:0] wd, input logic [31:0] rd);
    reset = rst; if_req_i = ireq; if_flush_i = fl; if_addr_i = iaddr;
    d_req_i = dreq; d_we_i = we; d_sel_i = sel; d_addr_i = daddr;
    d_wdata_i = wd; mem_rdata_i = rd;
    #2;
  endtask

  task automatic check_model();
    c_rst = reset;
    c_we  = d_we_i;
    c_fr  = if_req_i && !if_flush_i && !reset;
    c_dr  = d_req_i && !reset;
    c_ifw = c_fr && (!c_dr || m_starve == STARVE_MAX);
    c_dw  = c_dr && !c_ifw;
    check("if_gnt", if_gnt_o, c_ifw);
    check("d_gnt", d_gnt_o, c_dw);
    check("if_rvalid", if_rvalid_o, !reset && m_owed == 1 && !if_flush_i);
    check("d_rvalid", d_rvalid_o, !reset && m_owed == 2);
    check("if_rdata", if_rdata_o, mem_rdata_i);
    check("d_rdata", d_rdata_o, mem_rdata_i);
    check("mem_ce", mem_ce_o, c_ifw || c_dw);
    check("mem_we", mem_we_o, c_dw && d_we_i);
    check("mem_sel", mem_sel_o, c_ifw ? 4'hF : (c_dw ? d_sel_i : 4'h0));
    check("mem_addr", mem_addr_o, c_ifw ? if_addr_i : (c_dw ? d_addr_i : 32'h0));
    if (!c_ifw) check("mem_wdata", mem_wdata_o, c_dw ? d_wdata_i : 32'h0);
    check("conflict_cnt", conflict_cnt_o,
          (m_conflict > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_conflict);
  endtask

  task automatic tick();
    @(posedge clock);
    if (c_rst) begin
      m_owed = 0; m_starve = 0; m_conflict = 0;
    end else begin
      m_owed = c_ifw ? 1 : ((c_dw && !c_we) ? 2 : 0);
      if (c_fr && c_dr && c_dw)  m_starve++;
      else if (c_ifw || !c_fr)   m_starve = 0;
      if (c_fr && c_dr)          m_conflict++;
    end
    #1;
  endtask

  task automatic cyc(input logic rst, input logic ireq, input logic fl,
                     input logic [31:0] iaddr, input logic dreq, input logic we,
                     input logic [3:0] sel, input logic [31:0] daddr,
                     input logic [31:0] wd, input logic [31:0] rd);
    drive(rst, ireq, fl, iaddr, dreq, we, sel, daddr, wd, rd);
    check_model();
    tick();
  endtask

  task automatic idle(input logic [31:0] rd);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, rd);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    @(posedge clock); #1;
    do_reset();
    do_reset();
    check("reset_conflict", conflict_cnt_o, 32'd0);

    // Lone fetch: grant in cycle 0, data back in cycle 1.
    drive(1'b0, 1'b1, 1'b0, 32'h1c00_0000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
    check_model();
    check("lone_gnt", if_gnt_o, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0280_0413);
    check_model();
    check("lone_rvalid", if_rvalid_o, 1'b1);
    check("lone_rdata", if_rdata_o, 32'h0280_0413);
    check("lone_d_rvalid", d_rvalid_o, 1'b0);
    tick();

    // Conflict: data wins, returns next cycle, one contested cycle counted.
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 32'h40, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0, 32'h0);
    check_model();
    check("conf_gnt", {if_gnt_o, d_gnt_o}, 2'b01);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h1234_5678);
    check_model();
    check("conf_rvalid", d_rvalid_o, 1'b1);
    check("conf_cnt", conflict_cnt_o, 32'd1);
    tick();

    // Starvation: data x4, fetch forced through, then data again.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h80, 1'b1, 1'b0, 4'hF, 32'h300, 32'h0, $urandom);
      check_model();
      check("starve_gnt", {if_gnt_o, d_gnt_o}, (i == 4) ? 2'b10 : 2'b01);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
    check_model();
    check("starve_cnt", conflict_cnt_o, 32'd6);
    tick();

    // Write: byte-enabled RAM command, no read return.
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF, 32'h0);
    check_model();
    check("wr_we", mem_we_o, 1'b1);
    check("wr_sel", mem_sel_o, 4'h3);
    check("wr_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h5555_AAAA);
    check_model();
    check("wr_no_rvalid", d_rvalid_o, 1'b0);
    tick();

    // Flush kills the returning fetch, and masks a same-cycle fetch request.
    cyc(1'b0, 1'b1, 1'b0, 32'h44, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
    drive(1'b0, 1'b1, 1'b1, 32'h48, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0BAD_0BAD);
    check_model();
    check("flush_rvalid", if_rvalid_o, 1'b0);
    check("flush_gnt", if_gnt_o, 1'b0);
    check("flush_ce", mem_ce_o, 1'b0);
    tick();

    // Reset right after a granted data read: no return, counters cleared.
    cyc(1'b0, 1'b1, 1'b0, 32'h50, 1'b1, 1'b0, 4'hF, 32'h400, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h7777_7777);
    check_model();
    check("rst_d_rvalid", d_rvalid_o, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
    check_model();
    check("rst_conflict", conflict_cnt_o, 32'd0);
    check("rst_idle_rvalid", {if_rvalid_o, d_rvalid_o}, 2'b00);
    tick();

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 2) != 0,
          $urandom_range(0, 2) == 0, 4'($urandom), $urandom, $urandom, $urandom);
    end
    idle(32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mem_port_arbiter
